// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
//
// Contents:
//   state_t          FSM encoding (IDLE, ACCESS, DONE)
//   P_FETCH, P_DATA  port index constants (0 = instruction fetch, 1 = data)
//   AW_DEF, DW_DEF   default address / data widths
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - combinational two-way winner select
//
// Macro: MEM_ARB_RR_EN selects round-robin tie breaking; undefined gives
// fixed priority with port 0 winning every tie.
//
// Ports:
//   req0, req1  in   request levels of port 0 / port 1
//   last        in   index of the previous winner (round-robin only)
//   any         out  at least one request present
//   win         out  index of the selected port
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic win
);

  assign any = req0 | req1;

`ifdef MEM_ARB_RR_EN
  // On a tie, the port that did not win last time goes first.
  always_comb begin
    win = P_FETCH;
    if (req0 && req1) win = ~last;
    else if (req1)    win = P_DATA;
  end
`else
  // Port 0 always wins; the previous winner plays no role.
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = P_FETCH;
    if (!req0 && req1) win = P_DATA;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port access controller for a single-port word memory
//
// Macro: MEM_ARB_RR_EN enables round-robin arbitration (LAST register);
// undefined gives fixed priority to port 0.
//
// Ports:
//   CLK, RST_              clock, asynchronous active-low reset
//   REQ0/1, WE0/1          request level and write select per port
//   ADDR0/1, WDATA0/1      command address and write data per port
//   ACK0/1                 one-cycle completion pulse to the served port
//   RDATA                  registered read data, valid from the ACK cycle
//   BUSY                   high in ACCESS and DONE
//   CS, W, R, MADDR, MD    memory control, address and write data
//   MQ                     memory read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST_,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          CS,
  output logic          W,
  output logic          R,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MD,
  input  logic [DW-1:0] MQ
);

  state_t        state, state_n;
  logic          gnt, gnt_n;
  logic          last;
  logic          any, win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  logic          ack0_n, ack1_n, busy_n, cs_n, w_n, r_n;
  logic [AW-1:0] maddr_n;
  logic [DW-1:0] md_n, rdata_n;

  arb_pick2 u_pick (
    .req0 (REQ0),
    .req1 (REQ1),
    .last (last),
    .any  (any),
    .win  (win)
  );

  assign win_we    = (win == P_FETCH) ? WE0    : WE1;
  assign win_addr  = (win == P_FETCH) ? ADDR0  : ADDR1;
  assign win_wdata = (win == P_FETCH) ? WDATA0 : WDATA1;

`ifdef MEM_ARB_RR_EN
  // Reset value 1 lets port 0 win the first tie.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_)                   last <= P_DATA;
    else if (state == IDLE && any) last <= win;
  end
`else
  assign last = P_DATA;
`endif

  // MADDR/MD/W double as the latched command while the access is in flight.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    busy_n  = 1'b0;
    cs_n    = 1'b0;
    w_n     = 1'b0;
    r_n     = 1'b0;
    maddr_n = MADDR;
    md_n    = MD;
    rdata_n = RDATA;
    case (state)
      IDLE: begin
        if (any) begin
          state_n = ACCESS;
          gnt_n   = win;
          busy_n  = 1'b1;
          cs_n    = 1'b1;
          w_n     = win_we;
          r_n     = ~win_we;
          maddr_n = win_addr;
          md_n    = win_wdata;
        end
      end
      ACCESS: begin
        state_n = DONE;
        busy_n  = 1'b1;
        if (gnt == P_FETCH) ack0_n = 1'b1;
        else                ack1_n = 1'b1;
        if (R) rdata_n = MQ;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state <= IDLE;
      gnt   <= P_FETCH;
      ACK0  <= 1'b0;
      ACK1  <= 1'b0;
      BUSY  <= 1'b0;
      CS    <= 1'b0;
      W     <= 1'b0;
      R     <= 1'b0;
      MADDR <= '0;
      MD    <= '0;
      RDATA <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ACK0  <= ack0_n;
      ACK1  <= ack1_n;
      BUSY  <= busy_n;
      CS    <= cs_n;
      W     <= w_n;
      R     <= r_n;
      MADDR <= maddr_n;
      MD    <= md_n;
      RDATA <= rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       CLK = 1'b0;
  logic       RST_ = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [3:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] WDATA0 = '0, WDATA1 = '0;
  logic       ACK0, ACK1, BUSY, CS, W, R;
  logic [7:0] RDATA, MD, MQ;
  logic [3:0] MADDR;

  logic [7:0] mem [16];

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(4), .DW(8)) dut (
    .CLK(CLK), .RST_(RST_),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .BUSY(BUSY),
    .CS(CS), .W(W), .R(R), .MADDR(MADDR), .MD(MD), .MQ(MQ)
  );

  always #5 CLK = ~CLK;

  // Memory array model: synchronous write, read data only meaningful when selected.
  always @(posedge CLK) if (CS && W) mem[MADDR] <= MD;
  assign MQ = (CS && R) ? mem[MADDR] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One single access from IDLE, checking every cycle of the 3-cycle sequence.
  task automatic access(input int p, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    if (p == 0) begin REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = d; end
    else        begin REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = d; end
    tick();
    chk("acc_cs", CS, 1);
    chk("acc_w", W, we);
    chk("acc_r", R, !we);
    chk("acc_maddr", MADDR, a);
    if (we) chk("acc_md", MD, d);
    chk("acc_busy", BUSY, 1);
    chk("acc_noack", {ACK1, ACK0}, 0);
    tick();
    chk("done_ack", {ACK1, ACK0}, (p == 0) ? 2'b01 : 2'b10);
    chk("done_ctl", {CS, W, R}, 0);
    chk("done_busy", BUSY, 1);
    chk("done_rdata", RDATA, exp_rd);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    chk("idle_ack", {ACK1, ACK0}, 0);
    chk("idle_busy", BUSY, 0);
  endtask

  initial begin
    int n, cyc, last_c, c0, c1;
    logic [3:0] exp_ord;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    tick();
    chk("rst_outs", {ACK0, ACK1, CS, W, R, BUSY, MADDR, MD, RDATA}, 0);
    RST_ = 1'b1;
    tick();
    chk("post_rst_outs", {ACK0, ACK1, CS, W, R, BUSY, MADDR, MD, RDATA}, 0);

    // Write port 1, read back on port 0, write leaves RDATA alone
    access(1, 1'b1, 4'd3, 8'hA5, 8'h00);
    access(0, 1'b0, 4'd3, 8'h00, 8'hA5);
    access(0, 1'b1, 4'd7, 8'h11, 8'hA5);
    chk("rdata_hold", RDATA, 8'hA5);

    // Tie: both held for four accesses, starting from reset state
    RST_ = 1'b0;
    tick();
    RST_ = 1'b1;
    tick();
`ifdef MEM_ARB_RR_EN
    exp_ord = 4'b1010;
`else
    exp_ord = 4'b0000;
`endif
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd3;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd7;
    n = 0; cyc = 0; last_c = -1;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (ACK0 || ACK1) begin
        chk("tie_both_ack", {ACK0 & ACK1}, 0);
        chk("tie_order", {31'd0, ACK1}, {31'd0, exp_ord[n]});
        if (last_c >= 0) chk("tie_gap", cyc - last_c, 3);
        last_c = cyc;
        n++;
      end
    end
    chk("tie_count", n, 4);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    tick();
    chk("tie_idle", BUSY, 0);

    // Port 1 raised during port 0's ACCESS: delayed, not lost
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd7;
    tick();
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 4'd9; WDATA1 = 8'h5A;
    c0 = -100; c1 = 100; cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (ACK0) begin
        c0 = cyc;
        chk("late_rdata", RDATA, 8'h11);
        REQ0 = 1'b0;
      end
      if (ACK1) begin
        c1 = cyc;
        REQ1 = 1'b0;
        break;
      end
    end
    chk("late_ack0_at", c0, 1);
    chk("late_gap", c1 - c0, 3);
    tick();

    // Reset during a write ACCESS
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd5; WDATA0 = 8'h3C;
    tick();
    chk("rst_mid_cs_before", {CS, W}, 2'b11);
    REQ0 = 1'b0;
    #2;
    RST_ = 1'b0;
    #1;
    chk("rst_mid_async", {CS, W, R, BUSY, ACK0, ACK1}, 0);
    tick();
    chk("rst_mid_noack", {ACK0, ACK1, BUSY}, 0);
    RST_ = 1'b1;
    tick();
    access(0, 1'b1, 4'd5, 8'h3C, 8'h00);
    access(0, 1'b0, 4'd5, 8'h00, 8'h3C);

    // Persistent REQ0: ACK0 every third cycle
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd9;
    n = 0; cyc = 0; last_c = -1;
    while (n < 3 && cyc < 30) begin
      tick();
      cyc++;
      if (ACK0) begin
        if (n == 0) chk("pers_first", cyc, 2);
        else        chk("pers_gap", cyc - last_c, 3);
        chk("pers_rdata", RDATA, 8'h5A);
        last_c = cyc;
        n++;
      end
    end
    chk("pers_count", n, 3);
    REQ0 = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
